// File: rtl/ov_cfg_pkg.sv
// Shared types for the camera-sensor configuration sequencer: FSM encoding,
// ROM entry layout and the length of the master reset pulse issued on error.
package ov_cfg_pkg;

  localparam logic [2:0] ST_PWR_WAIT = 3'd0;
  localparam logic [2:0] ST_ID_ISSUE = 3'd1;
  localparam logic [2:0] ST_ID_WAIT  = 3'd2;
  localparam logic [2:0] ST_GAP      = 3'd3;
  localparam logic [2:0] ST_WR_ISSUE = 3'd4;
  localparam logic [2:0] ST_WR_WAIT  = 3'd5;
  localparam logic [2:0] ST_DONE     = 3'd6;
  localparam logic [2:0] ST_ERR      = 3'd7;

  typedef enum logic [2:0] {
    PWR_WAIT = ST_PWR_WAIT,
    ID_ISSUE = ST_ID_ISSUE,
    ID_WAIT  = ST_ID_WAIT,
    GAP      = ST_GAP,
    WR_ISSUE = ST_WR_ISSUE,
    WR_WAIT  = ST_WR_WAIT,
    DONE     = ST_DONE,
    ERR      = ST_ERR
  } state_e;

  localparam int unsigned ENTRY_W = 24;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
  } cfg_entry_t;

  localparam logic [3:0] ERR_RST_CYC = 4'd8;

endpackage

// File: rtl/ov_cfg_rom.sv
// Sensor init list: reg_idx -> {16-bit register address, 8-bit data}; combinational.
// Swapping sensors touches only this table and the top-level ID parameters.
module ov_cfg_rom
  import ov_cfg_pkg::*;
(
  input  logic [7:0] idx_i,
  output cfg_entry_t entry_o
);

  always_comb begin
    entry_o = '0;
    case (idx_i)
      8'd0:    entry_o = {16'h3103, 8'h11};
      8'd1:    entry_o = {16'h3008, 8'h82};
      8'd2:    entry_o = {16'h3008, 8'h42};
      8'd3:    entry_o = {16'h3103, 8'h03};
      8'd4:    entry_o = {16'h3017, 8'hFF};
      8'd5:    entry_o = {16'h3018, 8'hFF};
      8'd6:    entry_o = {16'h3034, 8'h1A};
      8'd7:    entry_o = {16'h3037, 8'h13};
      default: entry_o = '0;
    endcase
  end

endmodule

// File: rtl/ov_cfg_seq.sv
// Sensor bring-up sequencer: ID read then table writes via the I2C master; start
// one clock after ISSUE, end->start GAP_CYC+2; waits on i2c_end, bounded by TIMEOUT.
module ov_cfg_seq
  import ov_cfg_pkg::*;
#(
  parameter logic [7:0]  REG_NUM = 8'd200,
  parameter logic [15:0] PWR_DLY = 16'd1000,
  parameter logic [7:0]  GAP_CYC = 8'd16,
  parameter logic [15:0] TIMEOUT = 16'd4000,
  parameter logic [15:0] ID_ADDR = 16'h300A,
  parameter logic [7:0]  ID_VAL  = 8'h56
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        cfg_restart,
  input  logic        i2c_end,
  input  logic [7:0]  rd_data,
  output logic        i2c_start,
  output logic        wr_en,
  output logic        rd_en,
  output logic        addr_num,
  output logic [15:0] byte_addr,
  output logic [7:0]  wr_data,
  output logic [7:0]  reg_idx,
  output logic        cfg_done,
  output logic        cfg_err,
  output logic        i2c_rst_n
);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  reg_idx_q, reg_idx_d;
  logic [3:0]  err_cnt_q, err_cnt_d;
  logic        i2c_start_q, rd_en_q, wr_en_q, cfg_done_q, cfg_err_q, i2c_rst_n_q;
  logic [15:0] byte_addr_q;
  logic [7:0]  wr_data_q;
  cfg_entry_t  entry;

  ov_cfg_rom u_rom (
    .idx_i   (reg_idx_q),
    .entry_o (entry)
  );

  always_comb begin
    state_d   = state_q;
    reg_idx_d = reg_idx_q;
    case (state_q)
      PWR_WAIT: if (cnt_q + 16'd1 >= PWR_DLY) state_d = ID_ISSUE;
      ID_ISSUE: state_d = ID_WAIT;
      // i2c_end wins over a timeout reached on the same clock
      ID_WAIT: begin
        if (i2c_end)               state_d = (rd_data == ID_VAL) ? GAP : ERR;
        else if (cnt_q >= TIMEOUT) state_d = ERR;
      end
      GAP: begin
        if (cnt_q + 16'd1 >= {8'd0, GAP_CYC})
          state_d = (reg_idx_q < REG_NUM) ? WR_ISSUE : DONE;
      end
      WR_ISSUE: state_d = WR_WAIT;
      WR_WAIT: begin
        if (i2c_end) begin
          reg_idx_d = reg_idx_q + 8'd1;
          state_d   = GAP;
        end else if (cnt_q >= TIMEOUT) begin
          state_d = ERR;
        end
      end
      DONE, ERR: begin
        if (cfg_restart) begin
          state_d   = PWR_WAIT;
          reg_idx_d = '0;
        end
      end
      default: state_d = PWR_WAIT;
    endcase

    if ((state_d != state_q) || (state_q == DONE) || (state_q == ERR)) cnt_d = '0;
    else                                                               cnt_d = cnt_q + 16'd1;

    if ((state_q == ERR) && (state_d == ERR))
      err_cnt_d = (err_cnt_q == ERR_RST_CYC) ? err_cnt_q : err_cnt_q + 4'd1;
    else
      err_cnt_d = '0;
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q     <= PWR_WAIT;
      cnt_q       <= '0;
      reg_idx_q   <= '0;
      err_cnt_q   <= '0;
      i2c_start_q <= 1'b0;
      rd_en_q     <= 1'b0;
      wr_en_q     <= 1'b0;
      byte_addr_q <= '0;
      wr_data_q   <= '0;
      cfg_done_q  <= 1'b0;
      cfg_err_q   <= 1'b0;
      i2c_rst_n_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      reg_idx_q   <= reg_idx_d;
      err_cnt_q   <= err_cnt_d;
      i2c_start_q <= (state_q == ID_ISSUE) || (state_q == WR_ISSUE);
      // transaction selects stay up until the clock after i2c_end (or the timeout)
      rd_en_q     <= (state_q == ID_ISSUE) || ((state_q == ID_WAIT) && (state_d == ID_WAIT));
      wr_en_q     <= (state_q == WR_ISSUE) || ((state_q == WR_WAIT) && (state_d == WR_WAIT));
      if (state_q == ID_ISSUE) begin
        byte_addr_q <= ID_ADDR;
      end else if (state_q == WR_ISSUE) begin
        byte_addr_q <= entry.addr;
        wr_data_q   <= entry.data;
      end
      cfg_done_q  <= (state_d == DONE);
      cfg_err_q   <= (state_d == ERR);
      i2c_rst_n_q <= !((state_d == ERR) && (err_cnt_d < ERR_RST_CYC));
    end
  end

  assign i2c_start = i2c_start_q;
  assign wr_en     = wr_en_q;
  assign rd_en     = rd_en_q;
  assign addr_num  = 1'b1;
  assign byte_addr = byte_addr_q;
  assign wr_data   = wr_data_q;
  assign reg_idx   = reg_idx_q;
  assign cfg_done  = cfg_done_q;
  assign cfg_err   = cfg_err_q;
  assign i2c_rst_n = i2c_rst_n_q;

endmodule

// File: tb/tb_ov_cfg_seq.sv
// Directed bench for ov_cfg_seq with a behavioural I2C master that answers 50 clocks
// after each start; cycle numbers count edges since the last reset release.
module tb_ov_cfg_seq;

  logic        sys_clk     = 1'b0;
  logic        sys_rst_n   = 1'b0;
  logic        cfg_restart = 1'b0;
  logic        i2c_end;
  logic [7:0]  rd_data;
  logic        i2c_start, wr_en, rd_en, addr_num, cfg_done, cfg_err, i2c_rst_n;
  logic [15:0] byte_addr;
  logic [7:0]  wr_data, reg_idx;

  always #5 sys_clk = ~sys_clk;

  ov_cfg_seq #(
    .REG_NUM (8'd3),
    .PWR_DLY (16'd20),
    .GAP_CYC (8'd4),
    .TIMEOUT (16'd200),
    .ID_ADDR (16'h300A),
    .ID_VAL  (8'h56)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .cfg_restart (cfg_restart),
    .i2c_end     (i2c_end),
    .rd_data     (rd_data),
    .i2c_start   (i2c_start),
    .wr_en       (wr_en),
    .rd_en       (rd_en),
    .addr_num    (addr_num),
    .byte_addr   (byte_addr),
    .wr_data     (wr_data),
    .reg_idx     (reg_idx),
    .cfg_done    (cfg_done),
    .cfg_err     (cfg_err),
    .i2c_rst_n   (i2c_rst_n)
  );

  int n_vec = 0;
  int n_mis = 0;

  // master model state and start log
  int          cyc = 0;
  bit          pend = 1'b0;
  int          age = 0;
  int          cur_dly = 50;
  int          txn_no = 0;
  int          hang_txn = -1;
  int          slow_txn = -1;
  logic [7:0]  id_resp = 8'h56;
  int          both_cnt = 0;
  int          hold_bad = 0;
  int          st_cyc[$];
  logic        st_rd[$];
  logic        st_wr[$];
  logic [15:0] st_addr[$];
  logic [7:0]  st_dat[$];

  logic [15:0] exp_addr [4] = '{16'h300A, 16'h3103, 16'h3008, 16'h3008};
  logic [7:0]  exp_dat  [4] = '{8'h00, 8'h11, 8'h82, 8'h42};

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  initial begin
    i2c_end = 1'b0;
    rd_data = 8'h00;
    forever begin
      @(posedge sys_clk);
      #1;
      i2c_end = 1'b0;
      if (!sys_rst_n) begin
        cyc  = 0;
        pend = 1'b0;
      end else begin
        cyc++;
        if (!i2c_rst_n) pend = 1'b0;
        if (pend) begin
          age++;
          if (age == cur_dly) begin
            if (!(rd_en || wr_en)) hold_bad++;
            i2c_end = 1'b1;
            rd_data = id_resp;
            pend    = 1'b0;
          end
        end
        if (i2c_start) begin
          st_cyc.push_back(cyc);
          st_rd.push_back(rd_en);
          st_wr.push_back(wr_en);
          st_addr.push_back(byte_addr);
          st_dat.push_back(wr_data);
          txn_no  = rd_en ? 0 : txn_no + 1;
          pend    = (txn_no != hang_txn);
          age     = 0;
          cur_dly = (txn_no == slow_txn) ? 200 : 50;
        end
        if (rd_en && wr_en) both_cnt++;
      end
    end
  end

  task automatic clear_log();
    st_cyc.delete();
    st_rd.delete();
    st_wr.delete();
    st_addr.delete();
    st_dat.delete();
  endtask

  task automatic wait_flag(input string tag, input int bound, output int hit);
    hit = -1;
    for (int i = 0; i < bound; i++) begin
      @(posedge sys_clk);
      #2;
      if (cfg_done || cfg_err) begin
        hit = cyc;
        break;
      end
    end
    chk_eq({tag, "_seen"}, (hit >= 0), 1);
  endtask

  task automatic wait_cyc(input int target);
    for (int i = 0; i < 1000; i++) begin
      if (cyc >= target) break;
      @(posedge sys_clk);
      #2;
    end
    chk_eq("wait_cyc", cyc, target);
  endtask

  task automatic pulse_restart(output int r);
    cfg_restart = 1'b1;
    @(posedge sys_clk);
    #2;
    cfg_restart = 1'b0;
    r = cyc;
  endtask

  task automatic check_run(input string tag, input int base);
    chk_eq({tag, "_nstart"}, st_cyc.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < st_cyc.size()) begin
        chk_eq($sformatf("%s_st%0d_cyc", tag, i), st_cyc[i], base + 21 + 56 * i);
        chk_eq($sformatf("%s_st%0d_rd", tag, i), st_rd[i], (i == 0));
        chk_eq($sformatf("%s_st%0d_wr", tag, i), st_wr[i], (i != 0));
        chk_eq($sformatf("%s_st%0d_addr", tag, i), st_addr[i], exp_addr[i]);
        if (i > 0) chk_eq($sformatf("%s_st%0d_dat", tag, i), st_dat[i], exp_dat[i]);
      end
    end
  endtask

  initial begin
    int hit;
    int r;
    int lows;

    repeat (3) @(posedge sys_clk);
    #2;
    chk_eq("rst_start", i2c_start, 0);
    chk_eq("rst_wr_en", wr_en, 0);
    chk_eq("rst_rd_en", rd_en, 0);
    chk_eq("rst_addr_num", addr_num, 1);
    chk_eq("rst_byte_addr", byte_addr, 0);
    chk_eq("rst_wr_data", wr_data, 0);
    chk_eq("rst_reg_idx", reg_idx, 0);
    chk_eq("rst_done", cfg_done, 0);
    chk_eq("rst_err", cfg_err, 0);
    chk_eq("rst_i2c_rst_n", i2c_rst_n, 1);
    sys_rst_n = 1'b1;

    // nominal: last end driven at 239 -> done 5 clocks later
    wait_flag("nom", 1000, hit);
    chk_eq("nom_done_cyc", hit, 244);
    chk_eq("nom_done", cfg_done, 1);
    chk_eq("nom_err", cfg_err, 0);
    chk_eq("nom_reg_idx", reg_idx, 3);
    check_run("nom", 0);
    repeat (3) @(posedge sys_clk);
    #2;
    chk_eq("nom_done_hold", cfg_done, 1);

    // restart from DONE, with a stray restart pulse during the first GAP
    clear_log();
    pulse_restart(r);
    chk_eq("rs_done_drop", cfg_done, 0);
    wait_cyc(r + 73);
    cfg_restart = 1'b1;
    @(posedge sys_clk);
    #2;
    cfg_restart = 1'b0;
    wait_flag("rs", 1000, hit);
    chk_eq("rs_done_cyc", hit, r + 244);
    chk_eq("rs_done", cfg_done, 1);
    check_run("rs", r);

    // ID mismatch
    id_resp = 8'h55;
    clear_log();
    pulse_restart(r);
    wait_flag("id", 1000, hit);
    chk_eq("id_err_cyc", hit, r + 72);
    chk_eq("id_err", cfg_err, 1);
    chk_eq("id_done", cfg_done, 0);
    chk_eq("id_rd_en_drop", rd_en, 0);
    lows = 0;
    for (int i = 0; i < 20; i++) begin
      if (i2c_rst_n) break;
      lows++;
      @(posedge sys_clk);
      #2;
    end
    chk_eq("id_rst_n_low_len", lows, 8);
    repeat (20) @(posedge sys_clk);
    #2;
    chk_eq("id_nstart", st_cyc.size(), 1);
    chk_eq("id_err_hold", cfg_err, 1);

    // write 1 never ends: error 201 clocks after its start
    id_resp  = 8'h56;
    hang_txn = 2;
    clear_log();
    pulse_restart(r);
    chk_eq("to_err_drop", cfg_err, 0);
    wait_flag("to", 1000, hit);
    chk_eq("to_err_cyc", hit, r + 334);
    chk_eq("to_err", cfg_err, 1);
    chk_eq("to_reg_idx", reg_idx, 1);
    chk_eq("to_nstart", st_cyc.size(), 3);
    chk_eq("to_wr_en_drop", wr_en, 0);
    chk_eq("to_rst_n_low", i2c_rst_n, 0);

    // end arrives on the same clock the timeout is reached
    hang_txn = -1;
    slow_txn = 2;
    clear_log();
    pulse_restart(r);
    wait_flag("co", 1000, hit);
    chk_eq("co_done_cyc", hit, r + 394);
    chk_eq("co_done", cfg_done, 1);
    chk_eq("co_err", cfg_err, 0);
    chk_eq("co_nstart", st_cyc.size(), 4);
    if (st_cyc.size() == 4) chk_eq("co_st3_cyc", st_cyc[3], r + 339);

    // reset held 2 clocks in the middle of write 0
    slow_txn = -1;
    clear_log();
    pulse_restart(r);
    wait_cyc(r + 100);
    chk_eq("mr_pre_wr_en", wr_en, 1);
    sys_rst_n = 1'b0;
    @(posedge sys_clk);
    #2;
    chk_eq("mr_start", i2c_start, 0);
    chk_eq("mr_wr_en", wr_en, 0);
    chk_eq("mr_rd_en", rd_en, 0);
    chk_eq("mr_byte_addr", byte_addr, 0);
    chk_eq("mr_wr_data", wr_data, 0);
    chk_eq("mr_reg_idx", reg_idx, 0);
    chk_eq("mr_done", cfg_done, 0);
    chk_eq("mr_err", cfg_err, 0);
    chk_eq("mr_i2c_rst_n", i2c_rst_n, 1);
    @(posedge sys_clk);
    #2;
    clear_log();
    sys_rst_n = 1'b1;
    wait_flag("mr", 1000, hit);
    chk_eq("mr_done_cyc", hit, 244);
    chk_eq("mr_done_lvl", cfg_done, 1);
    chk_eq("mr_err_lvl", cfg_err, 0);
    check_run("mr", 0);

    chk_eq("rd_wr_overlap", both_cnt, 0);
    chk_eq("sel_hold_at_end", hold_bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
